wb_rom_arbiter: RTL and testbench

//  Two-master arbiter sharing one Wishbone B3 slave port, typically the boot/constant ROM, between CPU fetch (m0) and a DMA/loader (m1).

---
 rtl/wb_arb_pkg.sv | 32 +++
 rtl/wb_arb_rr.sv | 21 ++
 rtl/wb_rom_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_rom_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone B3 ROM arbiter.
package wb_arb_pkg;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned SW     = DW / 8;
  localparam int unsigned BEAT_W = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} arb_state_t;

  // Master-to-slave request payload.
  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
  } wb_m2s_t;

  // A beat with this cycle type closes a transfer, so ownership may move after it.
  function automatic logic cti_ends(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_END);
  endfunction

endpackage

// File: rtl/wb_arb_rr.sv
// Two-way round-robin picker: on a tie the master that did not own last wins.
module wb_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       any
);

  always_comb begin
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/wb_rom_arbiter.sv
// Shares one Wishbone B3 slave (boot ROM) between CPU fetch (m0) and a DMA/loader (m1),
// round-robin per cycle with a beat quota that forces handover at a transfer boundary.
module wb_rom_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16,
  parameter bit          PRIO_M0   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_m2s,
  input  logic [SW-1:0] m0_sel,
  input  logic [2:0]    m0_cti,
  input  logic [1:0]    m0_bte,
  output logic          m0_ack,
  output logic          m0_err,
  output logic          m0_rty,
  output logic [DW-1:0] m0_dat_s2m,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_m2s,
  input  logic [SW-1:0] m1_sel,
  input  logic [2:0]    m1_cti,
  input  logic [1:0]    m1_bte,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          m1_rty,
  output logic [DW-1:0] m1_dat_s2m,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_m2s,
  output logic [SW-1:0] s_sel,
  output logic [2:0]    s_cti,
  output logic [1:0]    s_bte,
  input  logic          s_ack,
  input  logic          s_err,
  input  logic          s_rty,
  input  logic [DW-1:0] s_dat_s2m,
  output logic [1:0]    grant,
  output logic          busy
);

  arb_state_t        state, state_nxt;
  logic              last, last_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic              pick, any;
  logic              beat, quota;
  wb_m2s_t           m0_req, m1_req, own;

  assign m0_req = '{cyc: m0_cyc, stb: m0_stb, we: m0_we, adr: m0_adr, dat: m0_dat_m2s,
                    sel: m0_sel, cti: m0_cti, bte: m0_bte};
  assign m1_req = '{cyc: m1_cyc, stb: m1_stb, we: m1_we, adr: m1_adr, dat: m1_dat_m2s,
                    sel: m1_sel, cti: m1_cti, bte: m1_bte};

  wb_arb_rr u_rr (
    .req  ({m1_cyc, m0_cyc}),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  // Request mux: only the owner reaches the slave; IDLE/GAP drive an all-zero request.
  always_comb begin
    own = '0;
    case (state)
      OWN0:    own = m0_req;
      OWN1:    own = m1_req;
      default: own = '0;
    endcase
  end

  assign s_cyc     = own.cyc;
  assign s_stb     = own.stb;
  assign s_we      = own.we;
  assign s_adr     = own.adr;
  assign s_dat_m2s = own.dat;
  assign s_sel     = own.sel;
  assign s_cti     = own.cti;
  assign s_bte     = own.bte;

  // Responses go to the owner only, and never after it has dropped cyc.
  assign m0_ack = (state == OWN0) & m0_cyc & s_ack;
  assign m0_err = (state == OWN0) & m0_cyc & s_err;
  assign m0_rty = (state == OWN0) & m0_cyc & s_rty;
  assign m1_ack = (state == OWN1) & m1_cyc & s_ack;
  assign m1_err = (state == OWN1) & m1_cyc & s_err;
  assign m1_rty = (state == OWN1) & m1_cyc & s_rty;

  assign m0_dat_s2m = s_dat_s2m;
  assign m1_dat_s2m = s_dat_s2m;

  assign grant = {state == OWN1, state == OWN0};
  assign busy  = |grant;

  assign beat  = s_cyc & s_stb & s_ack;
  assign quota = beat_cnt >= BEAT_W'(MAX_BEATS);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE, GAP: begin
        beat_nxt  = '0;
        state_nxt = any ? (pick ? OWN1 : OWN0) : IDLE;
      end
      OWN0: begin
        if (beat && !quota) beat_nxt = beat_cnt + BEAT_W'(1);
        if (!m0_cyc || (quota && m1_cyc && beat && cti_ends(m0_cti))) begin
          state_nxt = GAP;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (beat && !quota) beat_nxt = beat_cnt + BEAT_W'(1);
        if (!m1_cyc || (quota && m0_cyc && beat && cti_ends(m1_cti))) begin
          state_nxt = GAP;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= PRIO_M0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rom_arbiter.sv
// Directed bench for wb_rom_arbiter with a registered-ack ROM model and two scripted masters.
module tb_wb_rom_arbiter;
  import wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mcyc[2], mstb[2], mwe[2];
  logic [31:0] madr[2], mdw[2];
  logic [3:0]  msel[2];
  logic [2:0]  mcti[2];
  logic [1:0]  mbte[2];
  logic        mack[2], merr[2], mrty[2];
  logic [31:0] mdr[2];

  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_m2s;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  grant;
  logic        busy;

  logic        rom_ack = 1'b0;
  logic [31:0] rom_dat = 32'h0;

  int checks = 0, failures = 0, both_hi = 0;
  int a0, a1, a1b, gn, hn, wacks, k0, k1;
  logic [1:0] glog[16];
  int         hand[4];
  logic [1:0] wprev;

  wb_rom_arbiter #(.MAX_BEATS(16), .PRIO_M0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_adr(madr[0]), .m0_dat_m2s(mdw[0]),
    .m0_sel(msel[0]), .m0_cti(mcti[0]), .m0_bte(mbte[0]), .m0_ack(mack[0]), .m0_err(merr[0]),
    .m0_rty(mrty[0]), .m0_dat_s2m(mdr[0]),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_adr(madr[1]), .m1_dat_m2s(mdw[1]),
    .m1_sel(msel[1]), .m1_cti(mcti[1]), .m1_bte(mbte[1]), .m1_ack(mack[1]), .m1_err(merr[1]),
    .m1_rty(mrty[1]), .m1_dat_s2m(mdr[1]),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m2s(s_dat_m2s),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_ack(rom_ack), .s_err(1'b0), .s_rty(1'b0),
    .s_dat_s2m(rom_dat), .grant(grant), .busy(busy)
  );

  // ROM: registered ack on every other cycle while addressed; deliberately not reset.
  always @(posedge clk) begin
    rom_ack <= s_cyc & s_stb & ~rom_ack;
    rom_dat <= s_adr ^ 32'hA5A5_0000;
  end

  always @(negedge clk) begin
    if (mack[0] && mack[1]) both_hi <= both_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] beat_cti(input int i, input int nbeats, input int per,
                                          input bit classic);
    if (classic) return CTI_CLASSIC;
    if (i == nbeats - 1 || ((i + 1) % per) == 0) return CTI_END;
    return CTI_INCR;
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One Wishbone cycle of nbeats; cyc stays high until the last ack is seen.
  task automatic run_master(input int id, input logic [31:0] base, input int nbeats,
                            input int per, input bit classic, output int acks);
    int n;
    n = 0;
    acks = 0;
    @(posedge clk); #1;
    mcyc[id] = 1'b1; mstb[id] = 1'b1; madr[id] = base;
    mcti[id] = beat_cti(0, nbeats, per, classic);
    while (acks < nbeats && n < 600) begin
      @(negedge clk);
      n++;
      if (mack[id]) acks++;
      @(posedge clk); #1;
      if (acks < nbeats) begin
        madr[id] = base + 32'(acks * 4);
        mcti[id] = beat_cti(acks, nbeats, per, classic);
      end
    end
    mcyc[id] = 1'b0; mstb[id] = 1'b0; mcti[id] = 3'b000; madr[id] = 32'h0;
  endtask

  task automatic wait_m0_acks(input int target);
    int seen, n;
    seen = 0;
    n = 0;
    while (seen < target && n < 300) begin
      @(negedge clk);
      n++;
      if (mack[0]) seen++;
    end
  endtask

  // Records how many m0 acks had occurred each time m1 gains the grant.
  task automatic watch_handover(input int cycles);
    hn = 0; wacks = 0; wprev = 2'b00;
    repeat (cycles) begin
      @(negedge clk);
      if (mack[0]) wacks++;
      if (grant == 2'b10 && wprev != 2'b10) begin
        if (hn < 4) hand[hn] = wacks;
        hn++;
      end
      wprev = grant;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0; madr[i] = 32'h0; mdw[i] = 32'h0;
      msel[i] = 4'hF; mcti[i] = 3'b000; mbte[i] = 2'b00;
    end
    for (int i = 0; i < 4; i++) hand[i] = -1;

    // Reset with both masters requesting, then m0 wins the tie.
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h20;
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h24;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_scyc", 32'(s_cyc), 32'h0);
    check("rst_ack0", 32'(mack[0]), 32'h0);
    check("rst_ack1", 32'(mack[1]), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_nograntyet", 32'(grant), 32'h0);
    @(negedge clk);
    check("rel_grant_m0", 32'(grant), 32'h1);
    check("rel_scyc", 32'(s_cyc), 32'h1);
    check("rel_sadr", s_adr, 32'h20);
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    madr[0] = 32'h0; madr[1] = 32'h0;

    // Single classic read by m0.
    reset_dut();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h10; mcti[0] = CTI_CLASSIC;
    @(posedge clk);
    @(negedge clk);
    check("t2_grant", 32'(grant), 32'h1);
    check("t2_sadr", s_adr, 32'h10);
    check("t2_noack_yet", 32'(mack[0]), 32'h0);
    @(negedge clk);
    check("t2_ack0", 32'(mack[0]), 32'h1);
    check("t2_ack1", 32'(mack[1]), 32'h0);
    check("t2_dat0", mdr[0], 32'hA5A5_0010);
    check("t2_dat1", mdr[1], 32'hA5A5_0010);
    @(posedge clk); #1 mcyc[0] = 1'b0; mstb[0] = 1'b0; madr[0] = 32'h0;
    @(negedge clk);
    check("t2_drop_scyc", 32'(s_cyc), 32'h0);
    check("t2_drop_ack", 32'(mack[0]), 32'h0);
    @(negedge clk);
    check("t2_gap_grant", 32'(grant), 32'h0);

    // Both masters repeating single classic cycles alternate ownership.
    reset_dut();
    k0 = 0; k1 = 0; gn = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin run_master(0, 32'h40, 1, 1, 1'b1, a0); k0 += a0; end
      end
      begin
        for (int k = 0; k < 4; k++) begin run_master(1, 32'h80, 1, 1, 1'b1, a1); k1 += a1; end
      end
      begin
        wprev = 2'b00;
        repeat (80) begin
          @(negedge clk);
          if (grant != wprev && (gn > 0 || grant != 2'b00)) begin
            if (gn < 16) glog[gn] = grant;
            gn++;
          end
          wprev = grant;
        end
      end
    join
    check("t3_g0", 32'(glog[0]), 32'h1);
    check("t3_g1", 32'(glog[1]), 32'h0);
    check("t3_g2", 32'(glog[2]), 32'h2);
    check("t3_g3", 32'(glog[3]), 32'h0);
    check("t3_g4", 32'(glog[4]), 32'h1);
    check("t3_g5", 32'(glog[5]), 32'h0);
    check("t3_g6", 32'(glog[6]), 32'h2);
    check("t3_acks0", 32'(k0), 32'd4);
    check("t3_acks1", 32'(k1), 32'd4);

    // 40-beat m0 burst, end beats every 10; m1 twice 5-beat bursts from m0 beat 3.
    reset_dut();
    fork
      run_master(0, 32'h1000, 40, 10, 1'b0, a0);
      begin
        wait_m0_acks(3);
        run_master(1, 32'h2000, 5, 5, 1'b0, a1);
        run_master(1, 32'h2100, 5, 5, 1'b0, a1b);
      end
      watch_handover(300);
    join
    check("t4_handover1", 32'(hand[0]), 32'd20);
    check("t4_handover2", 32'(hand[1]), 32'd40);
    check("t4_m0_total", 32'(a0), 32'd40);
    check("t4_m1_first", 32'(a1), 32'd5);
    check("t4_m1_second", 32'(a1b), 32'd5);

    // End beats every 16: end at count 15 is under quota, incr beats hold, release at 32.
    reset_dut();
    fork
      run_master(0, 32'h3000, 40, 16, 1'b0, a0);
      begin
        wait_m0_acks(3);
        run_master(1, 32'h4000, 5, 5, 1'b0, a1);
      end
      watch_handover(300);
    join
    check("t5_handover", 32'(hand[0]), 32'd32);
    check("t5_m0_total", 32'(a0), 32'd40);
    check("t5_m1", 32'(a1), 32'd5);
    check("both_acks_high", 32'(both_hi), 32'd0);

    // Asynchronous reset in the middle of an m1 burst.
    reset_dut();
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h300; mcti[1] = CTI_INCR;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t6_pre_grant", 32'(grant), 32'h2);
    check("t6_pre_ack", 32'(mack[1]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_scyc", 32'(s_cyc), 32'h0);
    check("t6_async_ack", 32'(mack[1]), 32'h0);
    check("t6_async_grant", 32'(grant), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle", 32'(grant), 32'h0);
    @(negedge clk);
    check("t6_regrant", 32'(grant), 32'h2);
    check("t6_regrant_sadr", s_adr, 32'h300);
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
